procb_state_ctrl: RTL and testbench

//  Per-thread sequencer wrapped around the procb saved-state memory (instantiated inside).
//  On block start for thread T it fetches T's saved process_bytes state and presents it to
//  the block builder. It accepts the builder's update, applies bytes_total arithmetic and

---
 rtl/procb_state_ctrl_pkg.sv | 44 ++++
 rtl/procb_state_ctrl_if.sv | 39 +++
 rtl/procb_state_ctrl_saved_state.sv | 34 +++
 rtl/procb_state_ctrl.sv | 151 +++++++++++++++
 tb/tb_procb_state_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/procb_state_ctrl_pkg.sv
// ============================================================================
// procb_state_ctrl_pkg : saved-state field layout, pad phases, FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package procb_state_ctrl_pkg;

   localparam int PROCB_BT_W       = 16;
   localparam int PROCB_REM_W      = 7;
   localparam int PROCB_PAD_W      = 2;
   localparam int PROCB_PAD_LSB    = 0;
   localparam int PROCB_REM_LSB    = PROCB_PAD_LSB + PROCB_PAD_W;
   localparam int PROCB_BT_LSB     = PROCB_REM_LSB + PROCB_REM_W;
   localparam int PROCB_SAVE_WIDTH = PROCB_BT_LSB + PROCB_BT_W;

   localparam logic [PROCB_PAD_W-1:0] PAD_NONE     = 2'd0;
   localparam logic [PROCB_PAD_W-1:0] PAD_80_DONE  = 2'd1;
   localparam logic [PROCB_PAD_W-1:0] PAD_LEN_PEND = 2'd2;

   localparam logic [PROCB_REM_W-1:0] MAX_BLOCK_BYTES = 7'd64;

   // Field order matches the packed save word {bytes_total, rec_rem, pad}
   typedef struct packed {
      logic [PROCB_BT_W-1:0]  bytes_total;
      logic [PROCB_REM_W-1:0] rec_rem;
      logic [PROCB_PAD_W-1:0] pad;
   } saved_state_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WT   = 3'd2,
      ST_HOLD = 3'd3,
      ST_WR   = 3'd4
   } state_t;

   function automatic int thread_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/procb_state_ctrl_if.sv
// ============================================================================
// procb_state_ctrl_if : start / state-present / update handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface procb_state_ctrl_if #(
   parameter int THREAD_W = 2
);
   logic                start;
   logic                start_new;
   logic [THREAD_W-1:0] start_thread;
   logic                start_rdy;
   logic                st_valid;
   logic [THREAD_W-1:0] st_thread;
   logic [15:0]         st_bytes_total;
   logic [6:0]          st_rec_rem;
   logic [1:0]          st_pad;
   logic                upd_en;
   logic [6:0]          upd_bytes;
   logic [6:0]          upd_rec_rem;
   logic [1:0]          upd_pad;
   logic                upd_last;
   logic                err;

   modport master (
      output start, start_new, start_thread,
      output upd_en, upd_bytes, upd_rec_rem, upd_pad, upd_last,
      input  start_rdy, st_valid, st_thread, st_bytes_total, st_rec_rem, st_pad, err
   );

   modport slave (
      input  start, start_new, start_thread,
      input  upd_en, upd_bytes, upd_rec_rem, upd_pad, upd_last,
      output start_rdy, st_valid, st_thread, st_bytes_total, st_rec_rem, st_pad, err
   );
endinterface

`default_nettype wire

// File: rtl/procb_state_ctrl_saved_state.sv
// ============================================================================
// procb_saved_state : per-thread state RAM, registered read, no reset on array
// Rev 1.0
// ============================================================================
`default_nettype none

module procb_saved_state #(
   parameter int DEPTH  = 4,
   parameter int WIDTH  = 25,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  dout,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  din
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= din;
      end
      if (rd_en) begin
         dout <= mem[rd_addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/procb_state_ctrl.sv
// ============================================================================
// procb_state_ctrl : per-thread fetch / present / write-back sequencer for the
// procb saved state. Optional checker: define PROCB_STATE_CHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module procb_state_ctrl
   import procb_state_ctrl_pkg::*;
#(
   parameter int N_THREADS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   procb_state_ctrl_if.slave   bus
);

   localparam int THREAD_W = thread_w(N_THREADS);

   state_t                 state;
   logic [THREAD_W-1:0]    thr;
   logic                   new_comp;
   logic [N_THREADS-1:0]   valid;
   logic                   rdy;
   logic                   st_valid;
   saved_state_t           st;
   saved_state_t           wr_data;
   logic                   wr_last;

   saved_state_t           dout;
   saved_state_t           upd_state;
   logic [PROCB_BT_W-1:0]  bt_next;
   logic                   rd_en;
   logic                   wr_en;

   assign rd_en = (state == ST_RD);
   assign wr_en = (state == ST_WR);

   procb_saved_state #(
      .DEPTH  (N_THREADS),
      .WIDTH  (PROCB_SAVE_WIDTH),
      .ADDR_W (THREAD_W)
   ) u_saved_state (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_addr (thr),
      .dout    (dout),
      .wr_en   (wr_en),
      .wr_addr (thr),
      .din     (wr_data)
   );

`ifdef PROCB_STATE_CHECK_EN
   logic bt_carry;
   logic err_hit;
   logic err_reg;

   assign {bt_carry, bt_next} = {1'b0, st.bytes_total} + {10'd0, bus.upd_bytes};

   always_comb begin
      err_hit = 1'b0;
      if (state == ST_HOLD && bus.upd_en) begin
         if (bt_carry || bus.upd_bytes > MAX_BLOCK_BYTES ||
             bus.upd_rec_rem > MAX_BLOCK_BYTES || bus.upd_pad == 2'd3) begin
            err_hit = 1'b1;
         end
      end
      if (state != ST_HOLD && bus.upd_en) begin
         err_hit = 1'b1;
      end
      if (state == ST_IDLE && bus.start && !bus.start_new && !valid[bus.start_thread]) begin
         err_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else if (err_hit) begin
         err_reg <= 1'b1;
      end
   end

   assign bus.err = err_reg;
`else
   assign bt_next = st.bytes_total + {9'd0, bus.upd_bytes};
   assign bus.err = 1'b0;
`endif

   assign upd_state = {bt_next, bus.upd_rec_rem, bus.upd_pad};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         thr      <= '0;
         new_comp <= 1'b0;
         valid    <= '0;
         rdy      <= 1'b1;
         st_valid <= 1'b0;
         st       <= '0;
         wr_data  <= '0;
         wr_last  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  thr      <= bus.start_thread;
                  new_comp <= bus.start_new;
                  rdy      <= 1'b0;
                  state    <= ST_RD;
               end
            end
            ST_RD: begin
               state <= ST_WT;
            end
            ST_WT: begin
               // A fresh computation or a never-written slot must not expose stale RAM
               st       <= (new_comp || !valid[thr]) ? '0 : dout;
               st_valid <= 1'b1;
               state    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (bus.upd_en) begin
                  st_valid <= 1'b0;
                  wr_last  <= bus.upd_last;
                  wr_data  <= bus.upd_last ? '0 : upd_state;
                  state    <= ST_WR;
               end
            end
            ST_WR: begin
               valid[thr] <= !wr_last;
               rdy        <= 1'b1;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.start_rdy      = rdy;
   assign bus.st_valid       = st_valid;
   assign bus.st_thread      = thr;
   assign bus.st_bytes_total = st.bytes_total;
   assign bus.st_rec_rem     = st.rec_rem;
   assign bus.st_pad         = st.pad;

endmodule

`default_nettype wire

// File: tb/tb_procb_state_ctrl.sv
// ============================================================================
// tb_procb_state_ctrl : directed table, corner sequences and random blocks
// against a per-thread arithmetic model of the saved state.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_procb_state_ctrl;
   import procb_state_ctrl_pkg::*;

   localparam int N_THREADS = 4;
   localparam int TW        = 2;
`ifdef PROCB_STATE_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   procb_state_ctrl_if #(.THREAD_W(TW)) bus ();

   procb_state_ctrl #(.N_THREADS(N_THREADS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: what each thread should hold after its last write-back
   int unsigned m_bt    [N_THREADS];
   int unsigned m_rem   [N_THREADS];
   int unsigned m_pad   [N_THREADS];
   bit          m_valid [N_THREADS];
   bit          m_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int t; bit nw; int by; int rm; int pd; bit ls;
      int e_bt; int e_rem; int e_pad;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(int t, bit nw, int by, int rm, int pd, bit ls,
                               int e_bt, int e_rem, int e_pad);
      vec_t v;
      v.t = t; v.nw = nw; v.by = by; v.rm = rm; v.pd = pd; v.ls = ls;
      v.e_bt = e_bt; v.e_rem = e_rem; v.e_pad = e_pad;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_THREADS; i++) m_valid[i] = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_rdy"},   bus.start_rdy, 1);
      check({tag, "_valid"}, bus.st_valid, 0);
      check({tag, "_thr"},   bus.st_thread, 0);
      check({tag, "_bt"},    bus.st_bytes_total, 0);
      check({tag, "_rem"},   bus.st_rec_rem, 0);
      check({tag, "_pad"},   bus.st_pad, 0);
      check({tag, "_err"},   bus.err, 0);
   endtask

   // One full block: start, present, ignored busy start, update, write-back
   task automatic do_block(input int t, input bit nw, input int by, input int rm,
                           input int pd, input bit ls,
                           input int e_bt, input int e_rem, input int e_pad);
      int guard;
      int unsigned sum;
      guard = 0;
      while (bus.start_rdy !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      check("rdy_wait", bus.start_rdy, 1);
      bus.start        = 1'b1;
      bus.start_thread = TW'(t);
      bus.start_new    = nw;
      if (CHECK_EN && !nw && !m_valid[t]) m_err = 1'b1;
      tick();
      bus.start = 1'b0;
      check("rdy_low", bus.start_rdy, 0);
      check("lat0", bus.st_valid, 0);
      tick();
      check("lat1", bus.st_valid, 0);
      tick();
      check("lat2", bus.st_valid, 1);
      check("st_thread", bus.st_thread, t);
      check("st_bt", bus.st_bytes_total, e_bt);
      check("st_rem", bus.st_rec_rem, e_rem);
      check("st_pad", bus.st_pad, e_pad);

      bus.start        = 1'b1;
      bus.start_thread = TW'(t + 1);
      bus.start_new    = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy_hold", bus.st_valid, 1);
      check("busy_thr", bus.st_thread, t);

      bus.upd_en      = 1'b1;
      bus.upd_bytes   = 7'(by);
      bus.upd_rec_rem = 7'(rm);
      bus.upd_pad     = 2'(pd);
      bus.upd_last    = ls;
      tick();
      bus.upd_en = 1'b0;
      check("upd_ack", bus.st_valid, 0);
      check("wr_busy", bus.start_rdy, 0);
      tick();
      check("rdy_back", bus.start_rdy, 1);

      sum = e_bt + by;
      if (CHECK_EN && (sum > 65535 || by > 64 || rm > 64 || pd == 3)) m_err = 1'b1;
      if (ls) begin
         m_valid[t] = 1'b0;
      end else begin
         m_bt[t]    = sum % 65536;
         m_rem[t]   = rm;
         m_pad[t]   = pd;
         m_valid[t] = 1'b1;
      end
      check("err", bus.err, m_err);
   endtask

   task automatic model_block(input int t, input bit nw, input int by, input int rm,
                              input int pd, input bit ls);
      bit z;
      z = nw || !m_valid[t];
      do_block(t, nw, by, rm, pd, ls,
               z ? 0 : int'(m_bt[t]), z ? 0 : int'(m_rem[t]), z ? 0 : int'(m_pad[t]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.start_new = 1'b0; bus.start_thread = '0;
      bus.upd_en = 1'b0; bus.upd_bytes = '0; bus.upd_rec_rem = '0;
      bus.upd_pad = '0; bus.upd_last = 1'b0;
      rst_n = 1'b1;
      #3;
      apply_reset();
      check_idle("reset");

      vecs.push_back(mk(3, 1, 64, 5, 0, 0,   0, 0, 0));
      vecs.push_back(mk(3, 0, 64, 5, 0, 0,  64, 5, 0));
      for (int r = 0; r < 3; r++)
         for (int t = 0; t < 3; t++)
            vecs.push_back(mk(t, (r == 0), 64, 0, 0, 0, r * 64, 0, 0));
      vecs.push_back(mk(0, 0, 64, 3, 1, 0, 192, 0, 0));
      vecs.push_back(mk(1, 0, 64, 0, 0, 1, 192, 0, 0));
      vecs.push_back(mk(2, 0, 64, 0, 2, 0, 192, 0, 0));
      vecs.push_back(mk(1, 0, 10, 7, 1, 0,   0, 0, 0));
      vecs.push_back(mk(1, 0,  0, 7, 1, 0,  10, 7, 1));
      vecs.push_back(mk(0, 0,  0, 3, 1, 0, 256, 3, 1));
      vecs.push_back(mk(2, 0,  0, 0, 2, 0, 256, 0, 2));
      vecs.push_back(mk(3, 1,  1, 0, 0, 0,   0, 0, 0));
      foreach (vecs[i])
         do_block(vecs[i].t, vecs[i].nw, vecs[i].by, vecs[i].rm, vecs[i].pd, vecs[i].ls,
                  vecs[i].e_bt, vecs[i].e_rem, vecs[i].e_pad);

      // Reset during HOLD with an update pending: nothing is written back
      bus.start = 1'b1; bus.start_thread = 2'd0; bus.start_new = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("pre_rst_hold", bus.st_valid, 1);
      check("pre_rst_bt", bus.st_bytes_total, 256);
      bus.upd_en = 1'b1; bus.upd_bytes = 7'd5; bus.upd_rec_rem = 7'd1;
      bus.upd_pad = 2'd0; bus.upd_last = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      bus.upd_en = 1'b0;
      check_idle("midrst");
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();
      do_block(0, 0, 8, 2, 1, 0, 0, 0, 0);
      do_block(3, 0, 8, 2, 1, 0, 0, 0, 0);
      apply_reset();
      check_idle("reset2");

      // Walk thread 2 up to 65500, then cross the 16-bit boundary
      do_block(2, 1, 64, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k < 1023; k++) do_block(2, 0, 64, 0, 0, 0, k * 64, 0, 0);
      do_block(2, 0, 28, 0, 0, 0, 65472, 0, 0);
      do_block(2, 0, 64, 4, 2, 0, 65500, 0, 0);
      do_block(2, 0,  0, 4, 2, 0, 28, 4, 2);

      // Update outside HOLD is ignored
      bus.upd_en = 1'b1; bus.upd_bytes = 7'd33; bus.upd_last = 1'b1;
      tick();
      bus.upd_en = 1'b0; bus.upd_last = 1'b0;
      if (CHECK_EN) m_err = 1'b1;
      check("stray_upd_rdy", bus.start_rdy, 1);
      check("stray_upd_err", bus.err, m_err);
      do_block(2, 0, 1, 4, 2, 0, 28, 4, 2);

      for (int n = 0; n < 300; n++) begin
         int t, by, rm, pd;
         bit nw, ls;
         t  = $urandom_range(0, N_THREADS - 1);
         nw = ($urandom_range(0, 3) == 0);
         ls = ($urandom_range(0, 7) == 0);
         by = ($urandom_range(0, 15) == 0) ? $urandom_range(65, 127) : $urandom_range(0, 64);
         rm = ($urandom_range(0, 15) == 0) ? $urandom_range(65, 127) : $urandom_range(0, 64);
         pd = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
         model_block(t, nw, by, rm, pd, ls);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
